// File: rtl/fetch_stage_if.sv
// FE-stage bus: decode stall and AGEX redirect come in, the FE latch and the PC trace go out.
interface fetch_stage_if #(
  parameter int DBITS       = 32,
  parameter int INSTBITS    = 32,
  parameter int CANARY_BITS = 16
);
  logic                                      from_DE_to_FE;
  logic [DBITS:0]                            from_AGEX_to_FE;
  logic [3*DBITS+INSTBITS+CANARY_BITS-1:0]   FE_latch_out;
  logic [DBITS-1:0]                          pc_FE_out;

  modport master (
    input  from_DE_to_FE, from_AGEX_to_FE,
    output FE_latch_out, pc_FE_out
  );
  modport slave (
    output from_DE_to_FE, from_AGEX_to_FE,
    input  FE_latch_out, pc_FE_out
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction ROM and the FE latch feeding decode.
module fetch_stage #(
  parameter int                     DBITS          = 32,
  parameter int                     INSTBITS       = 32,
  parameter logic [DBITS-1:0]       START_PC       = 'h200,
  parameter int                     IMEM_ADDR_BITS = 14,
  parameter string                  IMEM_INIT      = "test.mem",
  parameter int                     CANARY_BITS    = 16,
  parameter logic [CANARY_BITS-1:0] CANARY_VAL     = 16'hC0DE
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master fe
);
  localparam int LW    = 3*DBITS + INSTBITS + CANARY_BITS;
  localparam int DEPTH = 1 << IMEM_ADDR_BITS;

  typedef enum logic [1:0] {S_RUN, S_STALL, S_REDIRECT} state_t;

  logic [INSTBITS-1:0] imem [0:DEPTH-1];

  state_t            state;
  logic [DBITS-1:0]  pc, inst_count;
  logic [LW-1:0]     fe_latch;

  logic              stall, br_cond;
  logic [DBITS-1:0]  br_target, pcplus, count_next;
  logic [INSTBITS-1:0] inst;

  assign stall      = fe.from_DE_to_FE;
  assign br_cond    = fe.from_AGEX_to_FE[DBITS];
  assign br_target  = fe.from_AGEX_to_FE[DBITS-1:0];
  assign inst       = imem[pc[IMEM_ADDR_BITS+1:2]];
  assign pcplus     = pc + DBITS'(4);
  assign count_next = inst_count + DBITS'(1);

  // Redirect beats stall: the wrong-path instruction is squashed, never held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= START_PC;
      inst_count <= '0;
      fe_latch   <= '0;
      state      <= S_RUN;
    end else if (br_cond) begin
      pc       <= br_target;
      fe_latch <= '0;
      state    <= S_REDIRECT;
    end else if (stall) begin
      state <= S_STALL;
    end else begin
      fe_latch   <= {inst, pc, pcplus, count_next, CANARY_VAL};
      pc         <= pcplus;
      inst_count <= count_next;
      state      <= S_RUN;
    end
  end

  assign fe.FE_latch_out = fe_latch;
  assign fe.pc_FE_out    = pc;

  // A redirect always leaves a bubble; any non-bubble entry carries the canary.
  always @(posedge clk) begin
    if (!reset) begin
      if (state == S_REDIRECT) assert (fe_latch == '0);
      assert (fe_latch == '0 || fe_latch[CANARY_BITS-1:0] == CANARY_VAL);
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected latch/PC per edge.
module tb_fetch_stage;
  localparam int DBITS = 32, INSTBITS = 32, CB = 16, AB = 14;
  localparam int LW    = 3*DBITS + INSTBITS + CB;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_stage_if bus ();
  fetch_stage #(.IMEM_INIT("")) dut (.clk(clk), .reset(reset), .fe(bus.master));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LW-1:0]    latch;
    logic [DBITS-1:0] pc;
  } exp_t;

  exp_t              exp_q[$];
  logic [INSTBITS-1:0] rom [DEPTH];
  logic [DBITS-1:0]  m_pc, m_cnt;
  logic [LW-1:0]     m_latch;
  int                n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h200;
    m_cnt   = '0;
    m_latch = '0;
  endtask

  // Drive one edge's inputs, predict, then compare just after the edge.
  task automatic cycle(input string tag, input logic st, input logic br, input logic [DBITS-1:0] tgt);
    exp_t e;
    bus.from_DE_to_FE   = st;
    bus.from_AGEX_to_FE = {br, tgt};
    if (br) begin
      m_pc    = tgt;
      m_latch = '0;
    end else if (!st) begin
      m_latch = {rom[m_pc[AB+1:2]], m_pc, m_pc + 32'd4, m_cnt + 32'd1, 16'hC0DE};
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    e.latch = m_latch;
    e.pc    = m_pc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".latch"}, bus.FE_latch_out, e.latch);
    chk({tag, ".pc"}, LW'(bus.pc_FE_out), LW'(e.pc));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = (i * 32'h9E3779B1) ^ 32'h13;
    rom[32'h80] = 32'h00500093;
    for (int i = 0; i < DEPTH; i++) dut.imem[i] = rom[i];
    bus.from_DE_to_FE   = 1'b0;
    bus.from_AGEX_to_FE = '0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("reset.latch", bus.FE_latch_out, '0);
    chk("reset.pc", LW'(bus.pc_FE_out), LW'(32'h200));
    reset = 1'b0;

    cycle("first", 1'b0, 1'b0, '0);
    chk("first.exact", bus.FE_latch_out, {32'h00500093, 32'h200, 32'h204, 32'h1, 16'hC0DE});

    repeat (3) cycle("stall", 1'b1, 1'b0, '0);
    cycle("stall_release", 1'b0, 1'b0, '0);

    cycle("br_over_stall", 1'b1, 1'b1, 32'h300);
    cycle("after_br", 1'b0, 1'b0, '0);

    cycle("b2b_a", 1'b0, 1'b1, 32'h400);
    cycle("b2b_b", 1'b0, 1'b1, 32'h123);
    cycle("unaligned", 1'b0, 1'b0, '0);

    cycle("pre_rst_br", 1'b0, 1'b1, 32'h240);
    cycle("pre_rst_stall", 1'b1, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst.latch", bus.FE_latch_out, '0);
    chk("async_rst.pc", LW'(bus.pc_FE_out), LW'(32'h200));
    @(negedge clk);
    reset = 1'b0;

    cycle("wrap_br", 1'b0, 1'b1, 32'h0000FFFC);
    cycle("wrap_top", 1'b0, 1'b0, '0);
    cycle("wrap_zero", 1'b0, 1'b0, '0);
    chk("wrap_zero.inst", LW'(bus.FE_latch_out[LW-1 -: INSTBITS]), LW'(rom[0]));

    for (int k = 0; k < 60; k++) begin
      logic [DBITS-1:0] t;
      t = DBITS'($urandom_range(0, 32'h1FFFF));
      cycle("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t);
    end

    force dut.inst_count = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    cycle("cnt_wrap", 1'b0, 1'b0, '0);
    chk("cnt_wrap.field", LW'(bus.FE_latch_out[CB +: DBITS]), '0);
    release dut.inst_count;
    reset = 1'b1;
    #1;
    model_reset();
    chk("final_rst.latch", bus.FE_latch_out, '0);
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst", 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
